maze_nav_ctrl: RTL and testbench
================================

// Module: maze_nav_ctrl
// PURPOSE
//  Player pose controller for the maze renderer, parametrised in maze size, heading resolution and animation speed.
//  Accepts FWD/BACK/LEFT/RIGHT commands, checks them against wall bitmaps, and animates each move or turn over frame ticks.
//  Drives the cell position, sub-cell offset and camera angle consumed by the ray-cast renderer.
//  Sits between the input logic (buttons) and the renderer; all logic runs in the clk domain.
// PARAMETERS
//  MAZE_W      5   maze width in cells (>=2)
//  MAZE_H      5   maze height in cells (>=2)
//  SUB_W       4   sub-cell offset width; one cell = 2**SUB_W units
//  MOVE_STEP   4   offset advance per tick; must divide 2**SUB_W
//  ANGLE_W     8   camera angle width; quarter turn Q = 2**(ANGLE_W-2)
//  ROT_STEP    16  angle change per tick; must divide Q (elaboration assertion)
//  START_X/Y   0/0 reset cell; START_HEAD 1 reset heading (0=N,1=E,2=S,3=W)
// PORTS
//  clk        in   1                        system clock
//  reset_n    in   1                        asynchronous reset, active low
//  tick       in   1                        frame-rate strobe, 1-cycle pulse
//  cmd_valid  in   1                        command offered
//  cmd        in   2                        0=FWD 1=BACK 2=LEFT 3=RIGHT
//  cmd_ready  out  1                        command accepted when valid&ready
//  hor_wall   in   (MAZE_H+1)*MAZE_W        bit y*MAZE_W+x = north edge of cell (x,y); row MAZE_H = south border
//  ver_wall   in   MAZE_H*(MAZE_W+1)        bit y*(MAZE_W+1)+x = west edge of cell (x,y); col MAZE_W = east border
//  pos_x/y    out  $clog2(MAZE_W/H)         current cell
//  sub_off    out  SUB_W                    progress toward the next cell
//  move_dir   out  2                        heading of the motion in progress
//  angle      out  ANGLE_W                  camera yaw; 0=N, increases clockwise
//  busy       out  1                        move or turn in progress
//  bump       out  1                        1-cycle pulse: move blocked
//  done       out  1                        1-cycle pulse: move or turn completed
// BEHAVIOUR
//  Reset values
//   - pos = START_X/Y; angle = START_HEAD*Q; sub_off = 0; move_dir = START_HEAD.
//   - busy = bump = done = 0; state = IDLE.
//  State machine
//   - IDLE: cmd_ready = 1. On valid&ready, register cmd and go to CHECK. A tick in the same cycle is ignored.
//   - CHECK (1 cycle, tick ignored)
//     - Heading h = angle[ANGLE_W-1 -: 2]. FWD moves along h, BACK along h^2.
//     - The target edge's wall bit set, or a target outside the grid (even with the bit clear) -> bump=1, back to IDLE.
//     - Otherwise set move_dir and go to MOVE.
//     - LEFT/RIGHT -> ROTATE.
//   - MOVE: each tick, sub_off += MOVE_STEP. On the tick where it would reach 2**SUB_W:
//     - pos steps one cell along move_dir and sub_off = 0;
//     - done=1 and the FSM returns to IDLE in the same cycle.
//   - ROTATE: each tick, angle -/+ ROT_STEP (LEFT/RIGHT), mod 2**ANGLE_W with wrap (0-16=240).
//     On reaching the target (start angle -/+ Q): done=1, back to IDLE.
//  Outputs
//   - busy = state != IDLE. cmd_ready = 0 outside IDLE.
//   - Latency: accept -> busy next cycle; a move/turn takes 2**SUB_W/MOVE_STEP or Q/ROT_STEP ticks.
//  Boundary rules
//   - Wall inputs are sampled only in CHECK; changes during MOVE have no effect.
//   - A reset_n assertion mid-animation returns the pose to its reset values immediately.
// CONFIGURATION
//  MAZE_NAV_CMD_QUEUE_EN defined: one-entry command buffer.
//   - cmd_ready = 1 while the buffer is empty, including while busy.
//   - On done, a buffered cmd enters CHECK the next cycle with no IDLE gap, and the buffer frees.
//   - A reset clears the buffer.
//  Undefined: no buffer; cmd_ready = (state == IDLE).
// STRUCTURE
//  maze_pkg: cmd_e, heading_e, nav_state_e, functions hor_idx()/ver_idx().
//  Sub-module maze_wall_lookup: combinational; (x, y, heading) -> blocked, including the out-of-grid check.
// TESTING
//  1. Reset, then FWD at (0,0) E with all walls clear
//     -> busy; sub_off 4, 8, 12 on ticks 1-3; tick 4: pos_x=1, sub_off=0, done.
//  2. FWD at (0,0) heading N -> bump pulse in CHECK, pose unchanged, busy low 2 cycles after accept.
//  3. ver_wall bit 1 set, FWD at (0,0) E -> bump; clear the bit, FWD again -> reaches (1,0).
//  4. LEFT from angle 0 -> 240, 224, 208, 192 over 4 ticks, done; then RIGHT x4 turns -> angle 192 (wraps through 0).
//  5. reset_n low on the 2nd tick of a MOVE -> pos=(0,0), sub_off=0, busy=0 at once.
//  6. QUEUE_EN: RIGHT then FWD back-to-back -> both accepted; FWD starts the cycle after RIGHT done.
//     Without QUEUE_EN, the second cmd is held (ready=0) until IDLE.

Source files
------------

// File: rtl/maze_pkg.sv
// maze_pkg: shared types and wall-index helpers for the maze pose controller.
//   cmd_e       - button command encoding (FWD/BACK/LEFT/RIGHT)
//   heading_e   - compass heading, 0=N increasing clockwise
//   nav_state_e - controller FSM states
//   hor_idx()   - bit index of the north edge of cell (x,y) in hor_wall
//   ver_idx()   - bit index of the west edge of cell (x,y) in ver_wall
package maze_pkg;

    typedef enum logic [1:0] {
        CmdFwd   = 2'd0,
        CmdBack  = 2'd1,
        CmdLeft  = 2'd2,
        CmdRight = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        HeadN = 2'd0,
        HeadE = 2'd1,
        HeadS = 2'd2,
        HeadW = 2'd3
    } heading_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCheck  = 2'd1,
        StMove   = 2'd2,
        StRotate = 2'd3
    } nav_state_e;

    function automatic int hor_idx(input int x, input int y, input int w);
        return y * w + x;
    endfunction

    function automatic int ver_idx(input int x, input int y, input int w);
        return y * (w + 1) + x;
    endfunction

endpackage

// File: rtl/maze_wall_lookup.sv
// maze_wall_lookup: combinational wall check for one step out of cell (x,y).
//   x, y      - current cell
//   heading   - direction of the intended step
//   hor_wall  - north edges per cell, last row is the south border
//   ver_wall  - west edges per cell, last column is the east border
//   blocked   - step hits a wall or would leave the grid
module maze_wall_lookup
    import maze_pkg::*;
#(
    parameter int MAZE_W = 5,
    parameter int MAZE_H = 5
) (
    input  logic [$clog2(MAZE_W)-1:0]     x,
    input  logic [$clog2(MAZE_H)-1:0]     y,
    input  logic [1:0]                    heading,
    input  logic [(MAZE_H+1)*MAZE_W-1:0]  hor_wall,
    input  logic [MAZE_H*(MAZE_W+1)-1:0]  ver_wall,
    output logic                          blocked
);

    localparam int XW  = $clog2(MAZE_W);
    localparam int YW  = $clog2(MAZE_H);
    localparam int HIW = $clog2((MAZE_H + 1) * MAZE_W);
    localparam int VIW = $clog2(MAZE_H * (MAZE_W + 1));

    logic [HIW-1:0] hi;
    logic [VIW-1:0] vi;

    always_comb begin
        blocked = 1'b0;
        hi      = '0;
        vi      = '0;
        unique case (heading_e'(heading))
            HeadN: begin
                hi      = HIW'(hor_idx(int'(x), int'(y), MAZE_W));
                blocked = (y == '0) || hor_wall[hi];
            end
            HeadS: begin
                // South edge of (x,y) is the north edge of (x,y+1).
                hi      = HIW'(hor_idx(int'(x), int'(y) + 1, MAZE_W));
                blocked = (y == YW'(MAZE_H - 1)) || hor_wall[hi];
            end
            HeadW: begin
                vi      = VIW'(ver_idx(int'(x), int'(y), MAZE_W));
                blocked = (x == '0) || ver_wall[vi];
            end
            HeadE: begin
                vi      = VIW'(ver_idx(int'(x) + 1, int'(y), MAZE_W));
                blocked = (x == XW'(MAZE_W - 1)) || ver_wall[vi];
            end
            default: blocked = 1'b1;
        endcase
    end

endmodule

// File: rtl/maze_nav_ctrl.sv
// maze_nav_ctrl: player pose controller for the ray-cast maze renderer.
//   clk, reset_n         - clock, asynchronous active-low reset
//   tick                 - frame strobe that advances animations
//   cmd_valid/cmd/ready  - command handshake (0=FWD 1=BACK 2=LEFT 3=RIGHT)
//   hor_wall, ver_wall   - wall bitmaps, sampled only while checking a move
//   pos_x, pos_y         - current cell
//   sub_off              - progress toward the next cell
//   move_dir             - heading of the current/last move
//   angle                - camera yaw, 0=N, clockwise
//   busy, bump, done     - status: animating, move blocked, move/turn finished
// Define MAZE_NAV_CMD_QUEUE_EN to add a one-entry command buffer that accepts a
// command while busy and starts it right after the current one completes.
module maze_nav_ctrl
    import maze_pkg::*;
#(
    parameter int MAZE_W     = 5,
    parameter int MAZE_H     = 5,
    parameter int SUB_W      = 4,
    parameter int MOVE_STEP  = 4,
    parameter int ANGLE_W    = 8,
    parameter int ROT_STEP   = 16,
    parameter int START_X    = 0,
    parameter int START_Y    = 0,
    parameter int START_HEAD = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          tick,
    input  logic                          cmd_valid,
    input  logic [1:0]                    cmd,
    output logic                          cmd_ready,
    input  logic [(MAZE_H+1)*MAZE_W-1:0]  hor_wall,
    input  logic [MAZE_H*(MAZE_W+1)-1:0]  ver_wall,
    output logic [$clog2(MAZE_W)-1:0]     pos_x,
    output logic [$clog2(MAZE_H)-1:0]     pos_y,
    output logic [SUB_W-1:0]              sub_off,
    output logic [1:0]                    move_dir,
    output logic [ANGLE_W-1:0]            angle,
    output logic                          busy,
    output logic                          bump,
    output logic                          done
);

    localparam int XW    = $clog2(MAZE_W);
    localparam int YW    = $clog2(MAZE_H);
    localparam int QTR_I = 2 ** (ANGLE_W - 2);

    localparam logic [ANGLE_W-1:0] QTR    = ANGLE_W'(QTR_I);
    localparam logic [ANGLE_W-1:0] ROT    = ANGLE_W'(ROT_STEP);
    localparam logic [SUB_W:0]     STEP   = (SUB_W + 1)'(MOVE_STEP);
    localparam logic [SUB_W:0]     CELL   = (SUB_W + 1)'(2 ** SUB_W);
    localparam logic [ANGLE_W-1:0] ANG_RST = ANGLE_W'(START_HEAD * QTR_I);

    if ((QTR_I % ROT_STEP) != 0) begin : g_bad_rot_step
        $error("ROT_STEP must divide the quarter turn");
    end
    if (((2 ** SUB_W) % MOVE_STEP) != 0) begin : g_bad_move_step
        $error("MOVE_STEP must divide the cell size");
    end

    nav_state_e          state_q, state_d;
    cmd_e                cmd_q, cmd_d;
    logic [XW-1:0]       pos_x_q, pos_x_d;
    logic [YW-1:0]       pos_y_q, pos_y_d;
    logic [SUB_W-1:0]    sub_q, sub_d;
    logic [1:0]          dir_q, dir_d;
    logic [ANGLE_W-1:0]  angle_q, angle_d;
    logic [ANGLE_W-1:0]  tgt_q, tgt_d;
    logic                done_q, done_d;
    logic                buf_valid_q, buf_valid_d;
    cmd_e                buf_cmd_q, buf_cmd_d;

    logic [1:0]          chk_dir;
    logic                blocked;
    logic                accept;
    logic [SUB_W:0]      sub_sum;

    // BACK walks opposite to the camera heading.
    assign chk_dir = (cmd_q == CmdBack) ? (angle_q[ANGLE_W-1 -: 2] ^ 2'd2)
                                        : angle_q[ANGLE_W-1 -: 2];

    maze_wall_lookup #(
        .MAZE_W (MAZE_W),
        .MAZE_H (MAZE_H)
    ) u_wall_lookup (
        .x        (pos_x_q),
        .y        (pos_y_q),
        .heading  (chk_dir),
        .hor_wall (hor_wall),
        .ver_wall (ver_wall),
        .blocked  (blocked)
    );

`ifdef MAZE_NAV_CMD_QUEUE_EN
    assign cmd_ready = !buf_valid_q;
`else
    assign cmd_ready = (state_q == StIdle);
`endif
    assign accept  = cmd_valid && cmd_ready;
    assign sub_sum = {1'b0, sub_q} + STEP;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        sub_d       = sub_q;
        dir_d       = dir_q;
        angle_d     = angle_q;
        tgt_d       = tgt_q;
        done_d      = 1'b0;
        buf_valid_d = buf_valid_q;
        buf_cmd_d   = buf_cmd_q;
        bump        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cmd_d   = cmd_e'(cmd);
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (cmd_q == CmdLeft) begin
                    tgt_d   = angle_q - QTR;
                    state_d = StRotate;
                end else if (cmd_q == CmdRight) begin
                    tgt_d   = angle_q + QTR;
                    state_d = StRotate;
                end else if (blocked) begin
                    bump    = 1'b1;
                    state_d = StIdle;
                end else begin
                    dir_d   = chk_dir;
                    state_d = StMove;
                end
            end
            StMove: begin
                if (tick) begin
                    if (sub_sum == CELL) begin
                        sub_d   = '0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                        unique case (heading_e'(dir_q))
                            HeadN: pos_y_d = pos_y_q - YW'(1);
                            HeadE: pos_x_d = pos_x_q + XW'(1);
                            HeadS: pos_y_d = pos_y_q + YW'(1);
                            HeadW: pos_x_d = pos_x_q - XW'(1);
                            default: ;
                        endcase
                    end else begin
                        sub_d = sub_sum[SUB_W-1:0];
                    end
                end
            end
            StRotate: begin
                if (tick) begin
                    angle_d = (cmd_q == CmdLeft) ? (angle_q - ROT) : (angle_q + ROT);
                    if (angle_d == tgt_q) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef MAZE_NAV_CMD_QUEUE_EN
        if (accept && (state_q != StIdle)) begin
            buf_valid_d = 1'b1;
            buf_cmd_d   = cmd_e'(cmd);
        end
        // A buffered command skips IDLE and goes straight to its check.
        if ((state_q != StIdle) && (state_d == StIdle) && buf_valid_q) begin
            state_d     = StCheck;
            cmd_d       = buf_cmd_q;
            buf_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cmd_q       <= CmdFwd;
            pos_x_q     <= XW'(START_X);
            pos_y_q     <= YW'(START_Y);
            sub_q       <= '0;
            dir_q       <= 2'(START_HEAD);
            angle_q     <= ANG_RST;
            tgt_q       <= ANG_RST;
            done_q      <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_cmd_q   <= CmdFwd;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            sub_q       <= sub_d;
            dir_q       <= dir_d;
            angle_q     <= angle_d;
            tgt_q       <= tgt_d;
            done_q      <= done_d;
            buf_valid_q <= buf_valid_d;
            buf_cmd_q   <= buf_cmd_d;
        end
    end

    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign sub_off  = sub_q;
    assign move_dir = dir_q;
    assign angle    = angle_q;
    assign busy     = (state_q != StIdle);
    assign done     = done_q;

endmodule

// File: tb/tb_maze_nav_ctrl.sv
// tb_maze_nav_ctrl: directed self-checking bench for maze_nav_ctrl (default parameters).
module tb_maze_nav_ctrl;

    logic        clk;
    logic        reset_n;
    logic        tick;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        cmd_ready;
    logic [29:0] hor_wall;
    logic [29:0] ver_wall;
    logic [2:0]  pos_x;
    logic [2:0]  pos_y;
    logic [3:0]  sub_off;
    logic [1:0]  move_dir;
    logic [7:0]  angle;
    logic        busy;
    logic        bump;
    logic        done;

    int vectors;
    int miscompares;

    maze_nav_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .hor_wall  (hor_wall),
        .ver_wall  (ver_wall),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .sub_off   (sub_off),
        .move_dir  (move_dir),
        .angle     (angle),
        .busy      (busy),
        .bump      (bump),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    // Offer a command in IDLE; returns in the CHECK cycle.
    task automatic send(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        chk("send_ready", cmd_ready, 1);
        cyc();
        cmd_valid = 1'b0;
        chk("send_busy", busy, 1);
    endtask

    // From the CHECK cycle of an unblocked move: sub_off 4,8,12 then arrival.
    task automatic run_move(input int ex, input int ey, input int edir);
        chk("mv_bump", bump, 0);
        cyc();
        chk("mv_dir", move_dir, edir);
        for (int k = 1; k <= 3; k++) begin
            pulse_tick();
            chk("mv_sub", sub_off, 4 * k);
        end
        pulse_tick();
        chk("mv_x", pos_x, ex);
        chk("mv_y", pos_y, ey);
        chk("mv_sub0", sub_off, 0);
        chk("mv_done", done, 1);
        chk("mv_idle", busy, 0);
        cyc();
        chk("mv_done_pulse", done, 0);
    endtask

    // Issue a turn from IDLE and check each of its four 16-unit steps.
    task automatic run_turn(input logic [7:0] start, input bit left);
        logic [7:0] exp_a;
        send(left ? 2'd2 : 2'd3);
        cyc();
        exp_a = start;
        for (int k = 1; k <= 4; k++) begin
            chk("turn_done_early", done, 0);
            pulse_tick();
            exp_a = left ? exp_a - 8'd16 : exp_a + 8'd16;
            chk("turn_angle", angle, exp_a);
        end
        chk("turn_done", done, 1);
        chk("turn_idle", busy, 0);
        cyc();
    endtask

    // FWD/BACK that must bump: bump in CHECK, idle next cycle, pose unchanged.
    task automatic expect_bump(input logic [1:0] c, input int ex, input int ey);
        send(c);
        chk("bump_pulse", bump, 1);
        cyc();
        chk("bump_clear", bump, 0);
        chk("bump_idle", busy, 0);
        chk("bump_x", pos_x, ex);
        chk("bump_y", pos_y, ey);
        chk("bump_nodone", done, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        tick        = 1'b0;
        cmd_valid   = 1'b0;
        cmd         = 2'd0;
        hor_wall    = '0;
        ver_wall    = '0;
        cyc();
        cyc();

        // Reset values
        chk("rst_x", pos_x, 0);
        chk("rst_y", pos_y, 0);
        chk("rst_sub", sub_off, 0);
        chk("rst_angle", angle, 64);
        chk("rst_dir", move_dir, 1);
        chk("rst_busy", busy, 0);
        chk("rst_bump", bump, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cmd_ready, 1);
        reset_n = 1'b1;
        cyc();

        // FWD east from (0,0)
        send(2'd0);
        chk("check_not_ready", cmd_ready, 0);
        run_move(1, 0, 1);

        // BACK moves west to (0,0) while still facing east
        send(2'd1);
        run_move(0, 0, 3);
        chk("back_angle", angle, 64);

        // East edge of (0,0) walled, then cleared
        ver_wall[1] = 1'b1;
        expect_bump(2'd0, 0, 0);
        ver_wall[1] = 1'b0;
        send(2'd0);
        run_move(1, 0, 1);

        // Face north at (1,0): leaving the grid bumps with all bits clear
        run_turn(8'd64, 1'b1);
        expect_bump(2'd0, 1, 0);
        chk("bump_angle", angle, 0);

        // LEFT from 0 wraps to 192, then four RIGHTs wrap back through 0
        run_turn(8'd0, 1'b1);
        chk("left_wrap", angle, 192);
        run_turn(8'd192, 1'b0);
        chk("right_wrap0", angle, 0);
        run_turn(8'd0, 1'b0);
        run_turn(8'd64, 1'b0);
        run_turn(8'd128, 1'b0);
        chk("right_x4", angle, 192);

        // FWD west; a wall raised mid-move is ignored
        send(2'd0);
        chk("w_bump", bump, 0);
        cyc();
        ver_wall[1] = 1'b1;
        for (int k = 0; k < 4; k++) pulse_tick();
        chk("wmid_x", pos_x, 0);
        chk("wmid_done", done, 1);
        cyc();

        // West border, then BACK (east) into the raised wall
        expect_bump(2'd0, 0, 0);
        expect_bump(2'd1, 0, 0);
        ver_wall[1] = 1'b0;

        // Face south; south edge of (0,0) is hor_wall bit 5
        run_turn(8'd192, 1'b1);
        hor_wall[5] = 1'b1;
        expect_bump(2'd0, 0, 0);
        hor_wall[5] = 1'b0;
        send(2'd0);
        run_move(0, 1, 2);

        // Reset asserted on the 2nd tick of a move
        send(2'd0);
        cyc();
        pulse_tick();
        chk("r5_sub", sub_off, 4);
        tick    = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("r5_x", pos_x, 0);
        chk("r5_y", pos_y, 0);
        chk("r5_sub0", sub_off, 0);
        chk("r5_busy", busy, 0);
        chk("r5_angle", angle, 64);
        chk("r5_dir", move_dir, 1);
        tick = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();

        // RIGHT followed immediately by FWD
        send(2'd3);
        cmd_valid = 1'b1;
        cmd       = 2'd0;
`ifdef MAZE_NAV_CMD_QUEUE_EN
        chk("q_ready_busy", cmd_ready, 1);
        cyc();
        cmd_valid = 1'b0;
        chk("q_full", cmd_ready, 0);
        for (int k = 0; k < 4; k++) pulse_tick();
        chk("q_angle", angle, 128);
        chk("q_done", done, 1);
        chk("q_nogap", busy, 1);
        chk("q_ready_free", cmd_ready, 1);
        run_move(0, 1, 2);
`else
        chk("nq_held", cmd_ready, 0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            chk("nq_held_rot", cmd_ready, 0);
            pulse_tick();
        end
        chk("nq_angle", angle, 128);
        chk("nq_done", done, 1);
        chk("nq_idle", busy, 0);
        chk("nq_ready", cmd_ready, 1);
        cyc();
        cmd_valid = 1'b0;
        chk("nq_accept", busy, 1);
        run_move(0, 1, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
